// File: rtl/bp_be_irq_scheduler_pkg.sv
// Shared types for the backend interrupt-entry scheduler.
package bp_be_pkg;

   typedef enum logic [2:0] {
      e_run,
      e_block,
      e_drain,
      e_take,
      e_wait
   } bp_be_irq_sched_state_e;

   function automatic int cnt_width(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/bp_be_irq_scheduler_if.sv
// Signal bundle between the system pipe / dispatch / calculator and the scheduler.
interface bp_be_irq_scheduler_if #(
   parameter int inflight_max_p = 4
);
   localparam int cnt_width_lp = $clog2(inflight_max_p + 1);

   logic                    interrupt_ready_i;
   logic                    dispatch_v_i;
   logic                    retire_v_i;
   logic                    commit_v_i;
   logic                    pipe_mem_ready_i;
   logic                    pipe_long_ready_i;
   logic                    ptw_busy_i;
   logic                    flush_i;
   logic                    dispatch_ready_o;
   logic                    interrupt_v_o;
   logic [cnt_width_lp-1:0] inflight_o;
   logic                    err_o;

   modport master (
      output interrupt_ready_i, dispatch_v_i, retire_v_i, commit_v_i,
             pipe_mem_ready_i, pipe_long_ready_i, ptw_busy_i, flush_i,
      input  dispatch_ready_o, interrupt_v_o, inflight_o, err_o
   );

   modport slave (
      input  interrupt_ready_i, dispatch_v_i, retire_v_i, commit_v_i,
             pipe_mem_ready_i, pipe_long_ready_i, ptw_busy_i, flush_i,
      output dispatch_ready_o, interrupt_v_o, inflight_o, err_o
   );
endinterface

// File: rtl/bp_be_irq_scheduler_counter.sv
// Saturating up/down in-flight counter with synchronous clear and sticky error.
module bp_be_inflight_counter #(
   parameter  int max_p    = 4,
   localparam int width_lp = $clog2(max_p + 1)
) (
   input  logic                clk_i,
   input  logic                reset_i,
   input  logic                clear_i,
   input  logic                up_i,
   input  logic                down_i,
   output logic [width_lp-1:0] count_o,
   output logic                err_o
);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_o <= '0;
         err_o   <= 1'b0;
      end else if (clear_i) begin
         count_o <= '0;
      end else if (up_i && !down_i) begin
         if (count_o == width_lp'(max_p)) err_o <= 1'b1;
         else                             count_o <= count_o + 1'b1;
      end else if (down_i && !up_i) begin
         if (count_o == '0) err_o   <= 1'b1;
         else               count_o <= count_o - 1'b1;
      end
   end

endmodule

// File: rtl/bp_be_irq_scheduler.sv
// Interrupt-entry sequencer: block dispatch, drain, strobe take, wait for flush.
module bp_be_irq_scheduler
   import bp_be_pkg::*;
#(
   parameter int inflight_max_p = 4,
   parameter int drain_guard_p  = 2
) (
   input logic               clk_i,
   input logic               reset_i,
   bp_be_irq_scheduler_if.slave irq
);

   localparam int cnt_width_lp   = $clog2(inflight_max_p + 1);
   localparam int guard_width_lp = cnt_width(drain_guard_p);

   bp_be_irq_sched_state_e    state_r, state_n;
   logic [guard_width_lp-1:0] guard_r, guard_n;
   logic [cnt_width_lp-1:0]   inflight;
   logic                      err;
   logic                      quiet;

   bp_be_inflight_counter #(.max_p(inflight_max_p)) counter (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .clear_i (irq.flush_i),
      .up_i    (irq.dispatch_v_i),
      .down_i  (irq.retire_v_i),
      .count_o (inflight),
      .err_o   (err)
   );

   assign quiet = (inflight == '0) & irq.pipe_mem_ready_i & irq.pipe_long_ready_i
                & ~irq.commit_v_i & ~irq.ptw_busy_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r <= e_run;
         guard_r <= '0;
      end else begin
         state_r <= state_n;
         guard_r <= guard_n;
      end
   end

   // Guard only counts consecutive quiet cycles inside e_drain; any disturbance restarts it.
   always_comb begin
      state_n = state_r;
      guard_n = '0;
      unique case (state_r)
         e_run:   if (irq.interrupt_ready_i && !irq.ptw_busy_i) state_n = e_block;
         e_block: state_n = irq.flush_i ? e_run : e_drain;
         e_drain: begin
            if (irq.flush_i || !irq.interrupt_ready_i) begin
               state_n = e_run;
            end else if (quiet) begin
               if (guard_r == guard_width_lp'(drain_guard_p)) state_n = e_take;
               else                                          guard_n = guard_r + 1'b1;
            end
         end
         e_take:  state_n = irq.flush_i ? e_run : e_wait;
         e_wait:  if (irq.flush_i) state_n = e_run;
         default: state_n = e_run;
      endcase
   end

   assign irq.dispatch_ready_o = (state_r == e_run);
   assign irq.interrupt_v_o    = (state_r == e_take);
   assign irq.inflight_o       = inflight;
   assign irq.err_o            = err;

endmodule

// File: tb/tb_bp_be_irq_scheduler.sv
// Randomized + directed scoreboard bench for bp_be_irq_scheduler.
module tb_bp_be_irq_scheduler;

   localparam int MAX = 4;
   localparam int G   = 2;
   localparam int RUN = 0, BLOCK = 1, DRAIN = 2, TAKE = 3, WAITF = 4;

   typedef struct {
      bit irq, disp, ret, com, mem, lng, ptw, fl, rst;
   } stim_t;

   typedef struct {
      int idx;
      bit rdy, iv, err;
      int cnt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bp_be_irq_scheduler_if #(.inflight_max_p(MAX)) bus ();

   bp_be_irq_scheduler #(.inflight_max_p(MAX), .drain_guard_p(G)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .irq     (bus)
   );

   exp_t  q[$];
   stim_t s;
   int    total = 0, bad = 0, cyc_n = 0, last_strobe = -1;
   int    m_cnt = 0, m_mode = RUN, m_qlen = 0;
   bit    m_err = 0;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s idx=%0d actual=%0d required=%0d", nm, idx, act, req);
      end
   endtask

   task automatic defaults();
      s = '{irq:0, disp:0, ret:0, com:0, mem:1, lng:1, ptw:0, fl:0, rst:0};
   endtask

   // Reference: counts are plain integers; interrupt is taken after G+1 consecutive quiet drain cycles.
   task automatic model();
      bit quiet;
      if (s.rst) begin
         m_cnt = 0; m_err = 0; m_mode = RUN; m_qlen = 0;
      end else begin
         quiet = (m_cnt == 0) && s.mem && s.lng && !s.com && !s.ptw;
         case (m_mode)
            RUN:   if (s.irq && !s.ptw) m_mode = BLOCK;
            BLOCK: begin m_mode = s.fl ? RUN : DRAIN; m_qlen = 0; end
            DRAIN: if (s.fl || !s.irq) m_mode = RUN;
                   else begin
                      m_qlen = quiet ? m_qlen + 1 : 0;
                      if (m_qlen == G + 1) m_mode = TAKE;
                   end
            TAKE:  m_mode = s.fl ? RUN : WAITF;
            default: if (s.fl) m_mode = RUN;
         endcase
         if (s.fl) m_cnt = 0;
         else if (s.disp && !s.ret) begin
            if (m_cnt == MAX) m_err = 1; else m_cnt++;
         end else if (s.ret && !s.disp) begin
            if (m_cnt == 0) m_err = 1; else m_cnt--;
         end
      end
   endtask

   task automatic tick();
      exp_t e;
      @(negedge clk);
      rst                   = s.rst;
      bus.interrupt_ready_i = s.irq;
      bus.dispatch_v_i      = s.disp;
      bus.retire_v_i        = s.ret;
      bus.commit_v_i        = s.com;
      bus.pipe_mem_ready_i  = s.mem;
      bus.pipe_long_ready_i = s.lng;
      bus.ptw_busy_i        = s.ptw;
      bus.flush_i           = s.fl;
      model();
      e.idx = cyc_n; e.rdy = (m_mode == RUN); e.iv = (m_mode == TAKE);
      e.err = m_err; e.cnt = m_cnt;
      q.push_back(e);
      cyc_n++;
   endtask

   task automatic do_reset(input int n);
      defaults(); s.rst = 1;
      repeat (n) tick();
      s.rst = 0;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk); #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("dispatch_ready", e.idx, 32'(bus.dispatch_ready_o), 32'(e.rdy));
            chk("interrupt_v",    e.idx, 32'(bus.interrupt_v_o),    32'(e.iv));
            chk("inflight",       e.idx, 32'(bus.inflight_o),       32'(e.cnt));
            chk("err",            e.idx, 32'(bus.err_o),            32'(e.err));
            if (bus.interrupt_v_o === 1'b1) last_strobe = e.idx;
         end
      end
   end

   initial begin : driver
      int rise;
      defaults(); s.rst = 1;
      tick();
      do_reset(2);

      // Idle pipe: rise at cycle 0, strobe at cycle 1+1+G+1, flush at cycle 7.
      defaults(); s.irq = 1; rise = cyc_n;
      tick();
      repeat (6) tick();
      s.fl = 1; tick();
      s.fl = 0; s.irq = 0; repeat (3) tick();
      // Sample index k shows the state of cycle k+1 relative to the rise.
      chk("latency", rise, 32'(last_strobe), 32'(rise + (1 + 1 + G + 1) - 1));

      // Drain with three in flight, retired one per cycle.
      do_reset(1);
      s.disp = 1; repeat (3) tick();
      s.disp = 0; s.irq = 1; repeat (2) tick();
      s.ret = 1; repeat (3) tick();
      s.ret = 0; repeat (8) tick();
      s.fl = 1; tick(); s.fl = 0; s.irq = 0; tick();

      // Long pipe busy, then a commit inside the guard window.
      s.irq = 1; s.lng = 0; repeat (12) tick();
      s.lng = 1; tick();
      s.com = 1; tick();
      s.com = 0; repeat (6) tick();
      s.fl = 1; tick(); s.fl = 0; s.irq = 0; tick();

      // Interrupt withdrawn while draining.
      s.irq = 1; s.lng = 0; repeat (3) tick();
      s.irq = 0; repeat (4) tick();
      s.lng = 1;

      // Page walk holds off blocking.
      s.irq = 1; s.ptw = 1; repeat (5) tick();
      s.ptw = 0; repeat (8) tick();
      s.fl = 1; tick(); s.fl = 0; s.irq = 0; tick();

      // Counter boundaries and reset while draining.
      do_reset(1);
      s.disp = 1; repeat (5) tick();
      s.disp = 0; tick();
      do_reset(1);
      s.ret = 1; tick();
      s.ret = 0; tick();
      s.disp = 1; s.ret = 1; tick();
      s.ret = 0; tick();
      s.ret = 1; tick();
      s.disp = 0; s.ret = 0; tick();
      s.irq = 1; s.mem = 0; repeat (4) tick();
      s.rst = 1; tick();
      s.rst = 0; repeat (2) tick();

      // Randomized traffic.
      defaults();
      for (int i = 0; i < 3000; i++) begin
         s.rst  = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 19) == 0) s.irq = ~s.irq;
         s.disp = ((m_mode == RUN) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 149) == 0);
         s.ret  = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 99) == 0);
         s.com  = s.ret && ($urandom_range(0, 1) == 0);
         s.mem  = ($urandom_range(0, 7) != 0);
         s.lng  = ($urandom_range(0, 7) != 0);
         s.ptw  = ($urandom_range(0, 9) == 0);
         s.fl   = (m_mode == WAITF) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 49) == 0);
         tick();
      end

      defaults(); tick();
      @(posedge clk); #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
